// File: rtl/dds_cfg_arbiter.sv
// Round-robin arbiter that serialises register-write bursts from NREQ requesters
// onto the DDS configuration bus and issues a sync pulse after committing bursts.
module dds_cfg_arbiter #(
    parameter int NREQ     = 2,
    parameter int SYNC_LEN = 2,
    parameter int IW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*9-1:0]    req_addr,
    input  logic [NREQ*24-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [8:0]           cfg_addr,
    output logic [23:0]          cfg_data,
    output logic                 cfg_wr_en,
    output logic                 cfg_sync,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic [7:0]           bad_addr_cnt
);

    localparam int SCW = (SYNC_LEN > 2) ? $clog2(SYNC_LEN) : 1;
    localparam logic [8:0] INSTR_ADDR = 9'h1FF;
    localparam logic [8:0] MAP_TOP    = 9'h11F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_SYNC
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   last_owner_reg;
    logic            commit_reg;
    logic [SCW-1:0]  sync_cnt_reg, sync_cnt_next;
    logic [8:0]      cfg_addr_reg;
    logic [23:0]     cfg_data_reg;
    logic            cfg_wr_en_reg;
    logic            cfg_sync_reg;
    logic [7:0]      bad_cnt_reg;

    logic [8:0]      addr_arr [NREQ];
    logic [23:0]     data_arr [NREQ];

    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;

    logic            beat_valid;
    logic            beat_last;
    logic [8:0]      beat_addr;
    logic [23:0]     beat_data;
    logic            accept;
    logic            beat_mapped;
    logic            beat_commit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign addr_arr[gi]  = req_addr[gi*9 +: 9];
        assign data_arr[gi]  = req_data[gi*24 +: 24];
        assign req_ready[gi] = (state_reg == ST_BURST) && (owner_reg == IW'(gi));
    end

    assign beat_valid  = req_valid[owner_reg];
    assign beat_last   = req_last[owner_reg];
    assign beat_addr   = addr_arr[owner_reg];
    assign beat_data   = data_arr[owner_reg];
    assign accept      = (state_reg == ST_BURST) && beat_valid;
    assign beat_mapped = (beat_addr <= MAP_TOP) || (beat_addr == INSTR_ADDR);
    assign beat_commit = accept && (beat_addr == INSTR_ADDR);

    // Round-robin search starting one past the previous owner, wrapping at NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = last_owner_reg;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        sync_cnt_next = sync_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                sync_cnt_next = '0;
                if (accept && beat_last) begin
                    state_next = (commit_reg || beat_commit) ? ST_SYNC : ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (sync_cnt_reg == SCW'(SYNC_LEN - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    sync_cnt_next = sync_cnt_reg + SCW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IW'(NREQ - 1);
            commit_reg     <= 1'b0;
            sync_cnt_reg   <= '0;
            cfg_addr_reg   <= '0;
            cfg_data_reg   <= '0;
            cfg_wr_en_reg  <= 1'b0;
            cfg_sync_reg   <= 1'b0;
            bad_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            sync_cnt_reg  <= sync_cnt_next;
            cfg_wr_en_reg <= 1'b0;
            // The sync register lags the SYNC state by one cycle so it always
            // rises after the final write strobe of the committing burst.
            cfg_sync_reg  <= (state_reg == ST_SYNC);

            if (state_reg == ST_IDLE && found) begin
                owner_reg      <= pick;
                last_owner_reg <= pick;
                commit_reg     <= 1'b0;
            end else if (beat_commit) begin
                commit_reg <= 1'b1;
            end

            if (accept) begin
                if (beat_mapped) begin
                    cfg_addr_reg  <= beat_addr;
                    cfg_data_reg  <= beat_data;
                    cfg_wr_en_reg <= 1'b1;
                end else if (bad_cnt_reg != 8'hFF) begin
                    bad_cnt_reg <= bad_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign cfg_addr     = cfg_addr_reg;
    assign cfg_data     = cfg_data_reg;
    assign cfg_wr_en    = cfg_wr_en_reg;
    assign cfg_sync     = cfg_sync_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign grant_id     = owner_reg;
    assign bad_addr_cnt = bad_cnt_reg;

endmodule

// File: tb/tb_dds_cfg_arbiter.sv
// Bench for dds_cfg_arbiter: table-driven bursts with a write scoreboard plus
// hand-written sequences for arbitration, bubbles, saturation and reset abort.
module tb_dds_cfg_arbiter;

    localparam int NREQ     = 2;
    localparam int SYNC_LEN = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*9-1:0] req_addr;
    logic [NREQ*24-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [8:0]        cfg_addr;
    logic [23:0]       cfg_data;
    logic              cfg_wr_en;
    logic              cfg_sync;
    logic              busy;
    logic [0:0]        grant_id;
    logic [7:0]        bad_addr_cnt;

    dds_cfg_arbiter #(.NREQ(NREQ), .SYNC_LEN(SYNC_LEN)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_sync     (cfg_sync),
        .busy         (busy),
        .grant_id     (grant_id),
        .bad_addr_cnt (bad_addr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [23:0] data;
    } wr_t;

    typedef struct {
        int          r;
        logic [8:0]  addr;
        logic [23:0] data;
        logic        last;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [9];
    wr_t  exp_q [$];
    int   wr_cycs [$];

    int n_cmp = 0;
    int n_bad = 0;
    int bad_exp = 0;
    int cyc = 0;
    int wr_total, sync_total, busy_total, sync_first, sync_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic clear_stats();
        wr_total   = 0;
        sync_total = 0;
        busy_total = 0;
        sync_first = -1;
        sync_last  = -1;
        wr_cycs.delete();
    endtask

    // Output monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            cyc++;
            if (busy) busy_total++;
            if (cfg_sync) begin
                sync_total++;
                if (sync_first < 0) sync_first = cyc;
                sync_last = cyc;
            end
            if (cfg_wr_en) begin
                wr_total++;
                wr_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", cfg_addr, cfg_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(cfg_addr), 32'(e.addr));
                    check("wr_data", 32'(cfg_data), 32'(e.data));
                end
            end
        end
    end

    task automatic finish_burst();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic idle(input int n);
        finish_burst();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        finish_burst();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        bad_exp = 0;
        resetn  = 1'b1;
    endtask

    // Presents one beat from requester r; returns on the negedge after acceptance.
    task automatic drive_beat(input int r, input logic [8:0] a, input logic [23:0] d,
                              input logic l, input logic mapped);
        int n;
        wr_t e;
        n = 0;
        req_valid[r]         = 1'b1;
        req_addr[r*9 +: 9]   = a;
        req_data[r*24 +: 24] = d;
        req_last[r]          = l;
        while (!req_ready[r] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'(req_ready), 32'(1 << r));
        end else begin
            if (mapped) begin
                e.addr = a;
                e.data = d;
                exp_q.push_back(e);
            end else begin
                bad_exp = (bad_exp >= 255) ? 255 : bad_exp + 1;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_vec(input int i);
        drive_beat(vecs[i].r, vecs[i].addr, vecs[i].data, vecs[i].last, vecs[i].exp_wr);
        if (vecs[i].last) finish_burst();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        wr_t e;

        vecs[0] = '{0, 9'h000, 24'd6711,    1'b0, 1'b1};
        vecs[1] = '{0, 9'h001, 24'd13422,   1'b0, 1'b1};
        vecs[2] = '{0, 9'h100, 24'd0,       1'b1, 1'b1};
        vecs[3] = '{0, 9'h005, 24'd1000,    1'b0, 1'b1};
        vecs[4] = '{0, 9'h1FF, 24'h000081,  1'b1, 1'b1};
        vecs[5] = '{0, 9'h150, 24'hAAAAAA,  1'b1, 1'b0};
        vecs[6] = '{0, 9'h1FE, 24'h555555,  1'b1, 1'b0};
        vecs[7] = '{0, 9'h11F, 24'h123456,  1'b1, 1'b1};
        vecs[8] = '{0, 9'h120, 24'h654321,  1'b1, 1'b0};

        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_last  = '0;
        resetn    = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);

        check("rst_cfg_addr",  32'(cfg_addr), 32'd0);
        check("rst_cfg_data",  32'(cfg_data), 32'd0);
        check("rst_cfg_wr_en", 32'(cfg_wr_en), 32'd0);
        check("rst_cfg_sync",  32'(cfg_sync), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_grant_id",  32'(grant_id), 32'd0);
        check("rst_bad_cnt",   32'(bad_addr_cnt), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        resetn = 1'b1;
        idle(2);

        // Plain 3-beat burst.
        clear_stats();
        for (int i = 0; i <= 2; i++) apply_vec(i);
        idle(4);
        check("b3_wr_total", 32'(wr_total), 32'd3);
        check("b3_wr_consec", 32'(wr_cycs[2] - wr_cycs[0]), 32'd2);
        check("b3_sync_total", 32'(sync_total), 32'd0);
        check("b3_busy_cycles", 32'(busy_total), 32'd3);

        // Committing burst followed by sync.
        clear_stats();
        for (int i = 3; i <= 4; i++) apply_vec(i);
        idle(6);
        check("cm_wr_total", 32'(wr_total), 32'd2);
        check("cm_sync_total", 32'(sync_total), 32'(SYNC_LEN));
        check("cm_sync_after_wr", 32'(sync_first - wr_cycs[1]), 32'd1);
        check("cm_sync_run", 32'(sync_last - sync_first), 32'(SYNC_LEN - 1));
        check("cm_busy_cycles", 32'(busy_total), 32'(2 + SYNC_LEN));
        check("cm_idle_busy", 32'(busy), 32'd0);

        // Round-robin alternation with both requesters continuously valid.
        do_reset();
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            e.addr = (k % 2 == 0) ? 9'h010 : 9'h020;
            e.data = (k % 2 == 0) ? 24'h0000A0 : 24'h0000B1;
            exp_q.push_back(e);
        end
        req_addr  = {9'h020, 9'h010};
        req_data  = {24'h0000B1, 24'h0000A0};
        req_last  = 2'b11;
        req_valid = 2'b11;
        acc = 0;
        n   = 0;
        while (acc < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) acc++;
        end
        check("rr_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        idle(4);
        check("rr_wr_total", 32'(wr_total), 32'd4);

        // Owner bubble: requester 1 waits through requester 0's stalled burst.
        clear_stats();
        req_valid[1]   = 1'b1;
        req_addr[9 +: 9]   = 9'h030;
        req_data[24 +: 24] = 24'h00C0DE;
        req_last[1]    = 1'b1;
        drive_beat(0, 9'h040, 24'h000011, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("bub_ready_held", 32'(req_ready), 32'b01);
        drive_beat(0, 9'h041, 24'h000022, 1'b0, 1'b1);
        drive_beat(0, 9'h042, 24'h000033, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        drive_beat(1, 9'h030, 24'h00C0DE, 1'b1, 1'b1);
        idle(4);
        check("bub_wr_total", 32'(wr_total), 32'd4);
        check("bub_gap", 32'(wr_cycs[1] - wr_cycs[0]), 32'd3);
        check("bub_resume", 32'(wr_cycs[2] - wr_cycs[1]), 32'd1);

        // Unmapped addresses and saturation.
        clear_stats();
        for (int i = 5; i <= 6; i++) apply_vec(i);
        idle(2);
        check("bad_cnt_two", 32'(bad_addr_cnt), 32'(bad_exp));
        check("bad_no_write", 32'(wr_total), 32'd0);
        for (int i = 7; i <= 8; i++) apply_vec(i);
        idle(2);
        check("bad_boundary_wr", 32'(wr_total), 32'd1);
        check("bad_boundary_cnt", 32'(bad_addr_cnt), 32'(bad_exp));
        for (int i = 0; i < 300; i++) begin
            drive_beat(0, 9'h120 + 9'(i % 223), 24'(i), 1'b1, 1'b0);
        end
        idle(2);
        check("bad_saturated", 32'(bad_addr_cnt), 32'd255);
        check("bad_model", 32'(bad_exp), 32'd255);

        // Reset asserted during the first cfg_sync cycle aborts the sync.
        clear_stats();
        drive_beat(1, 9'h1FF, 24'h000001, 1'b1, 1'b1);
        finish_burst();
        @(negedge clk);
        check("abort_sync_on", 32'(cfg_sync), 32'd1);
        check("abort_busy_on", 32'(busy), 32'd1);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_sync_off", 32'(cfg_sync), 32'd0);
        check("abort_busy_off", 32'(busy), 32'd0);
        check("abort_wr_off", 32'(cfg_wr_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        bad_exp = 0;
        clear_stats();
        req_addr  = {9'h050, 9'h040};
        req_data  = {24'h000009, 24'h000007};
        req_last  = 2'b11;
        req_valid = 2'b11;
        resetn    = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'b01);
        check("post_rst_grant", 32'(grant_id), 32'd0);
        e.addr = 9'h040;
        e.data = 24'h000007;
        exp_q.push_back(e);
        @(negedge clk);
        idle(4);
        check("post_rst_no_sync", 32'(sync_total), 32'd0);
        check("post_rst_wr", 32'(wr_total), 32'd1);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
